sync_fifo: RTL and testbench

Single-clock, parameterized first-in first-out buffer with registered read data and full/empty status flags. It is the device under test of the FIFO verification environment, with SVA and functional coverage. It buffers `FIFO_WIDTH`-bit words between a producer and a consumer in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 16 +
 rtl/sync_fifo_if.sv | 21 ++
 rtl/sync_fifo_mem.sv | 36 +++
 rtl/sync_fifo.sv | 104 ++++++++++
 tb/tb_sync_fifo.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the single-clock FIFO.
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bus of the FIFO; the FIFO itself sits on the slave modport.
interface sync_fifo_if #(
    parameter int FIFO_WIDTH = fifo_pkg::DEF_FIFO_WIDTH
);
    logic                  write_en;
    logic                  read_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;

    modport master (
        output write_en, read_en, data_in,
        input  data_out, empty, full
    );

    modport slave (
        input  write_en, read_en, data_in,
        output data_out, empty, full
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read port.
// Read data appears the cycle after re_i and holds until the next read.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; read data valid one cycle after acceptance.
// Writes while full are dropped unless a read is accepted in the same cycle; reads while empty are ignored.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rstN,
    sync_fifo_if.slave  bus
);
    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int CNT_W = cnt_width(FIFO_DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_acc, rd_acc;
    logic             empty, full;
    logic             was_full_q;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign rd_acc = bus.read_en && !empty;
    // A read in the same cycle frees the slot, so a full FIFO can still take a write.
    assign wr_acc = bus.write_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rstN),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_in),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (bus.data_out)
    );

    assign bus.empty = empty;
    assign bus.full  = full;

    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            was_full_q <= 1'b0;
        end else if (full) begin
            was_full_q <= 1'b1;
        end else if (empty) begin
            was_full_q <= 1'b0;
        end
    end

    a_no_wr_when_full: assert property (@(posedge clk) disable iff (rstN)
        !(wr_acc && full && !rd_acc));
    a_no_rd_when_empty: assert property (@(posedge clk) disable iff (rstN)
        !(rd_acc && empty));
    a_flags_exclusive: assert property (@(posedge clk) disable iff (rstN)
        !(empty && full));
    a_count_bound: assert property (@(posedge clk) disable iff (rstN)
        count_q <= CNT_W'(FIFO_DEPTH));

    c_full_reached: cover property (@(posedge clk) disable iff (rstN) full);
    c_empty_after_full: cover property (@(posedge clk) disable iff (rstN)
        was_full_q && empty);
    c_ptr_wrap: cover property (@(posedge clk) disable iff (rstN)
        wr_acc && (wr_ptr_q == '1));
    c_rw_when_full: cover property (@(posedge clk) disable iff (rstN)
        full && wr_acc && rd_acc);
    c_rw_when_empty: cover property (@(posedge clk) disable iff (rstN)
        empty && bus.write_en && bus.read_en);
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: fill/drain, overflow drop, underflow hold, full streaming, async reset.
module tb_sync_fifo;
    logic clk  = 1'b0;
    logic rstN = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    sync_fifo_if #(.FIFO_WIDTH(8)) bus ();

    sync_fifo #(.FIFO_WIDTH(8), .FIFO_DEPTH(16)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set before the edge; outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [7:0] d);
        bus.write_en = we;
        bus.read_en  = re;
        bus.data_in  = d;
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00);
        step();
        step();
        #2 rstN = 1'b0;

        // 1: idle after reset
        repeat (3) step();
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        check_eq("rst_full", 32'(bus.full), 32'd0);
        check_eq("rst_dout", 32'(bus.data_out), 32'h0);

        // 2: fill 0x01..0x10, drain in order
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(i + 1));
            step();
            if (i == 0)  check_eq("t2_not_empty", 32'(bus.empty), 32'd0);
            if (i == 14) check_eq("t2_not_full_15", 32'(bus.full), 32'd0);
        end
        drive(1'b0, 1'b0, 8'h00);
        check_eq("t2_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            step();
            check_eq("t2_rd", 32'(bus.data_out), 32'(i + 1));
            if (i == 14) check_eq("t2_not_empty_15", 32'(bus.empty), 32'd0);
        end
        drive(1'b0, 1'b0, 8'h00);
        check_eq("t2_empty", 32'(bus.empty), 32'd1);

        // 3: overflow write of 0xFF is dropped
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'hA0 + i));
            step();
        end
        drive(1'b1, 1'b0, 8'hFF);
        step();
        check_eq("t3_full_hold", 32'(bus.full), 32'd1);
        check_eq("t3_count", 32'(dut.count_q), 32'd16);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            step();
            check_eq("t3_rd", 32'(bus.data_out), 32'(8'hA0 + i));
        end
        drive(1'b0, 1'b0, 8'h00);
        check_eq("t3_empty", 32'(bus.empty), 32'd1);

        // 4: read while empty holds data_out
        drive(1'b0, 1'b1, 8'h00);
        step();
        step();
        drive(1'b0, 1'b0, 8'h00);
        check_eq("t4_dout_hold", 32'(bus.data_out), 32'hAF);
        check_eq("t4_count", 32'(dut.count_q), 32'd0);
        check_eq("t4_empty", 32'(bus.empty), 32'd1);

        // 5: stream through a full FIFO for 20 cycles
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'h30 + i));
            step();
        end
        check_eq("t5_full_pre", 32'(bus.full), 32'd1);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, 8'(8'h50 + k));
            step();
            check_eq("t5_rw_dout", 32'(bus.data_out),
                     (k < 16) ? 32'(8'h30 + k) : 32'(8'h50 + k - 16));
            check_eq("t5_rw_full", 32'(bus.full), 32'd1);
        end
        drive(1'b0, 1'b0, 8'h00);
        check_eq("t5_wr_ptr", 32'(dut.wr_ptr_q), 32'd4);
        check_eq("t5_rd_ptr", 32'(dut.rd_ptr_q), 32'd4);
        for (int k = 20; k < 36; k++) begin
            drive(1'b0, 1'b1, 8'h00);
            step();
            check_eq("t5_drain", 32'(bus.data_out), 32'(8'h50 + k - 16));
        end
        drive(1'b0, 1'b0, 8'h00);
        check_eq("t5_empty", 32'(bus.empty), 32'd1);

        // 6: async reset mid-operation
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'(8'hC0 + i));
            step();
        end
        drive(1'b0, 1'b0, 8'h00);
        check_eq("t6_pre_empty", 32'(bus.empty), 32'd0);
        #2 rstN = 1'b1;
        #1;
        check_eq("t6_async_empty", 32'(bus.empty), 32'd1);
        check_eq("t6_async_dout", 32'(bus.data_out), 32'h0);
        check_eq("t6_async_count", 32'(dut.count_q), 32'd0);
        drive(1'b1, 1'b1, 8'h77);
        step();
        check_eq("t6_rst_ignore", 32'(dut.count_q), 32'd0);
        drive(1'b0, 1'b0, 8'h00);
        #3 rstN = 1'b0;
        step();
        drive(1'b1, 1'b0, 8'h5A);
        step();
        drive(1'b0, 1'b1, 8'h00);
        step();
        drive(1'b0, 1'b0, 8'h00);
        check_eq("t6_rd_5a", 32'(bus.data_out), 32'h5A);
        check_eq("t6_post_empty", 32'(bus.empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
